// File: rtl/data_axi_pkg.sv
// Shared types and constants for the data-side AXI master bridge.
// Holds the bridge FSM state encoding and the AXI size/response/burst codes it uses.
package data_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP,
        DONE
    } state_e;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Combinational AXI write-strobe generator for a 32-bit bus.
// Lanes shifted past bit 3 by a misaligned address are simply lost.
module axi_wstrb_gen
    import data_axi_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b0000;
        case (size)
            SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
            SIZE_HALF: wstrb = 4'b0011 << addr_lo;
            SIZE_WORD: wstrb = 4'b1111;
            default:   wstrb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/data_axi_bridge.sv
// MEM-stage data-side AXI4 master: single-beat loads, one or two single-beat stores.
// Optional macro DATA_AXI_RESP_CHECK_EN reports non-OKAY responses on resp_err.
module data_axi_bridge
    import data_axi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int AXI_ID = 1
)(
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    input  logic            req_wr,
    input  logic            req_two,
    input  logic [31:0]     addr1,
    input  logic [31:0]     addr2,
    input  logic [31:0]     data1,
    input  logic [31:0]     data2,
    input  logic [1:0]      size1,
    input  logic [1:0]      size2,
    output logic            mem_stall,
    output logic            rdata_valid,
    output logic [31:0]     rdata,
    output logic            resp_err,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata_in,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    state_e      state_q, state_d;
    logic        second_q, second_d;
    logic        aw_ok_q, aw_ok_d;
    logic        w_ok_q, w_ok_d;
    logic        two_q, two_d;
    logic [31:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic [31:0] data1_q, data1_d, data2_q, data2_d;
    logic [1:0]  size1_q, size1_d, size2_q, size2_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    logic [1:0]  cur_size;
    logic        rresp_bad;
    logic        bresp_bad;
    logic        unused_ids;

    assign cur_addr = second_q ? addr2_q : addr1_q;
    assign cur_data = second_q ? data2_q : data1_q;
    assign cur_size = second_q ? size2_q : size1_q;

`ifdef DATA_AXI_RESP_CHECK_EN
    assign rresp_bad = (rresp != AXI_OKAY);
    assign bresp_bad = (bresp != AXI_OKAY);
    assign resp_err  = rdata_valid & err_q;
`else
    logic unused_resp;
    assign rresp_bad   = 1'b0;
    assign bresp_bad   = 1'b0;
    assign resp_err    = 1'b0;
    assign unused_resp = ^{rresp, bresp, err_q};
`endif

    assign unused_ids = ^{rid, bid};

    always_comb begin
        state_d  = state_q;
        second_d = second_q;
        aw_ok_d  = aw_ok_q;
        w_ok_d   = w_ok_q;
        two_d    = two_q;
        addr1_d  = addr1_q;
        addr2_d  = addr2_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        size1_d  = size1_q;
        size2_d  = size2_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    two_d    = req_wr & req_two;
                    addr1_d  = addr1;
                    addr2_d  = addr2;
                    data1_d  = data1;
                    data2_d  = data2;
                    size1_d  = size1;
                    size2_d  = size2;
                    second_d = 1'b0;
                    aw_ok_d  = 1'b0;
                    w_ok_d   = 1'b0;
                    err_d    = 1'b0;
                    state_d  = req_wr ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rvalid) begin
                    if (rresp_bad) err_d = 1'b1;
                    if (rlast) begin
                        rdata_d = rdata_in;
                        state_d = DONE;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W complete independently; a handshake already taken stays taken.
                aw_ok_d = aw_ok_q | awready;
                w_ok_d  = w_ok_q | wready;
                if ((aw_ok_q | awready) && (w_ok_q | wready)) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid) begin
                    if (bresp_bad) err_d = 1'b1;
                    if (!second_q && two_q) begin
                        second_d = 1'b1;
                        aw_ok_d  = 1'b0;
                        w_ok_d   = 1'b0;
                        state_d  = WR_ADDR_DATA;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            second_q <= 1'b0;
            aw_ok_q  <= 1'b0;
            w_ok_q   <= 1'b0;
            two_q    <= 1'b0;
            addr1_q  <= 32'd0;
            addr2_q  <= 32'd0;
            data1_q  <= 32'd0;
            data2_q  <= 32'd0;
            size1_q  <= SIZE_BYTE;
            size2_q  <= SIZE_BYTE;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            second_q <= second_d;
            aw_ok_q  <= aw_ok_d;
            w_ok_q   <= w_ok_d;
            two_q    <= two_d;
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            size1_q  <= size1_d;
            size2_q  <= size2_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    axi_wstrb_gen u_wstrb_gen (
        .size    (cur_size),
        .addr_lo (cur_addr[1:0]),
        .wstrb   (wstrb)
    );

    assign mem_stall   = req_valid & (state_q != DONE);
    assign rdata_valid = (state_q == DONE);
    assign rdata       = rdata_q;

    assign arid    = ID_W'(AXI_ID);
    assign araddr  = cur_addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, cur_size};
    assign arburst = BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (state_q == RD_ADDR);
    assign rready  = (state_q == RD_DATA);

    assign awid    = ID_W'(AXI_ID);
    assign awaddr  = cur_addr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, cur_size};
    assign awburst = BURST_INCR;
    assign awlock  = 1'b0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = (state_q == WR_ADDR_DATA) && !aw_ok_q;
    assign wdata   = cur_data;
    assign wlast   = 1'b1;
    assign wvalid  = (state_q == WR_ADDR_DATA) && !w_ok_q;
    assign bready  = (state_q == WR_RESP);

endmodule

// File: tb/tb_data_axi_bridge.sv
// Self-checking bench for data_axi_bridge: AXI slave model with programmable ready/response
// delays, plus a scoreboard of expected AR/AW/W beats and completion pulses.
`timescale 1ns/1ps
module tb_data_axi_bridge;
    import data_axi_pkg::*;

    localparam int ID_W = 4;

`ifdef DATA_AXI_RESP_CHECK_EN
    localparam logic RESP_EXP = 1'b1;
`else
    localparam logic RESP_EXP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn;
    logic            req_valid, req_wr, req_two;
    logic [31:0]     addr1, addr2, data1, data2;
    logic [1:0]      size1, size2;
    logic            mem_stall, rdata_valid, resp_err;
    logic [31:0]     rdata;
    logic [ID_W-1:0] arid, awid, rid, bid;
    logic [31:0]     araddr, awaddr, rdata_in, wdata;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, awsize, arprot, awprot;
    logic [1:0]      arburst, awburst, rresp, bresp;
    logic [3:0]      arcache, awcache, wstrb;
    logic            arlock, awlock, arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    data_axi_bridge #(.ID_W(ID_W), .AXI_ID(1)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_wr(req_wr), .req_two(req_two),
        .addr1(addr1), .addr2(addr2), .data1(data1), .data2(data2),
        .size1(size1), .size2(size2),
        .mem_stall(mem_stall), .rdata_valid(rdata_valid), .rdata(rdata), .resp_err(resp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_in(rdata_in), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [1:0] size; } addr_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; } wbeat_t;
    typedef struct { logic is_load; logic [31:0] rdata; logic err; } done_t;

    addr_t  exp_ar[$];
    addr_t  exp_aw[$];
    wbeat_t exp_w[$];
    done_t  exp_done[$];

    int compared = 0;
    int mismatched = 0;

    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [1:0]  bresp_first = 2'b00;
    logic [31:0] rword_cfg = 32'd0;

    int ar_n, aw_n, w_n, b_n, pulse_n;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt, b_idx;
    bit r_pend, b_pend, aw_seen, w_seen;
    addr_t  ea;
    wbeat_t ew;
    done_t  ed;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // AXI slave model and scoreboard. Everything is evaluated on the falling edge: readies and
    // responses are driven there, and a handshake is recorded when valid & ready will both be
    // high at the following rising edge.
    initial begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rlast = 0;
        rid = 4'd1; bid = 4'd1; rdata_in = 0; rresp = 0; bresp = 0;
        ar_n = 0; aw_n = 0; w_n = 0; b_n = 0; pulse_n = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0; b_idx = 0;
        r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
        forever begin
            @(negedge clk);
            if (resetn !== 1'b1) begin
                arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rlast = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0; b_idx = 0;
                r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
                exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_done.delete();
            end else begin
                if (r_pend && r_cnt >= r_delay) begin
                    rvalid = 1; rlast = 1; rdata_in = rword_cfg; rresp = rresp_cfg;
                end else begin
                    rvalid = 0; rlast = 0;
                    if (r_pend) r_cnt++;
                end
                if (rvalid && rready) r_pend = 0;

                if (b_pend && b_cnt >= b_delay) begin
                    bvalid = 1;
                    bresp = (b_idx == 0) ? bresp_first : AXI_OKAY;
                end else begin
                    bvalid = 0;
                    if (b_pend) b_cnt++;
                end
                if (bvalid && bready) begin
                    b_pend = 0; b_n++; b_idx++;
                end

                if (arvalid) begin
                    arready = (ar_cnt >= ar_delay);
                    if (!arready) ar_cnt++;
                end else begin
                    arready = 0; ar_cnt = 0;
                end
                if (arvalid && arready) begin
                    ar_n++; ar_cnt = 0; r_pend = 1; r_cnt = 0;
                    if (exp_ar.size() == 0) checkOutput("ar_unexpected", 32'(arvalid), 0);
                    else begin
                        ea = exp_ar.pop_front();
                        checkOutput("araddr", araddr, ea.addr);
                        checkOutput("arsize", 32'(arsize), {30'd0, ea.size});
                    end
                    checkOutput("arlen", 32'(arlen), 0);
                    checkOutput("arid", 32'(arid), 1);
                end

                if (awvalid) begin
                    awready = (aw_cnt >= aw_delay);
                    if (!awready) aw_cnt++;
                end else begin
                    awready = 0; aw_cnt = 0;
                end
                if (awvalid && awready) begin
                    aw_n++; aw_cnt = 0; aw_seen = 1;
                    if (exp_aw.size() == 0) checkOutput("aw_unexpected", 32'(awvalid), 0);
                    else begin
                        ea = exp_aw.pop_front();
                        checkOutput("awaddr", awaddr, ea.addr);
                        checkOutput("awsize", 32'(awsize), {30'd0, ea.size});
                    end
                    checkOutput("awburst", 32'(awburst), 1);
                    checkOutput("awid", 32'(awid), 1);
                end

                if (wvalid) begin
                    wready = (w_cnt >= w_delay);
                    if (!wready) w_cnt++;
                end else begin
                    wready = 0; w_cnt = 0;
                end
                if (wvalid && wready) begin
                    w_n++; w_cnt = 0; w_seen = 1;
                    if (exp_w.size() == 0) checkOutput("w_unexpected", 32'(wvalid), 0);
                    else begin
                        ew = exp_w.pop_front();
                        checkOutput("wdata", wdata, ew.data);
                        checkOutput("wstrb", 32'(wstrb), {28'd0, ew.strb});
                    end
                    checkOutput("wlast", 32'(wlast), 1);
                end

                if (aw_seen && w_seen) begin
                    b_pend = 1; b_cnt = 0; aw_seen = 0; w_seen = 0;
                end

                if (rdata_valid) begin
                    pulse_n++; b_idx = 0;
                    if (exp_done.size() == 0) checkOutput("pulse_unexpected", 32'(rdata_valid), 0);
                    else begin
                        ed = exp_done.pop_front();
                        if (ed.is_load) checkOutput("rdata", rdata, ed.rdata);
                        checkOutput("resp_err", 32'(resp_err), {31'd0, ed.err});
                    end
                end
            end
        end
    end

    // Drive one MEM-stage request, queue its expected bus traffic and completion, then hold it
    // until the completion pulse while checking that the pipeline stays stalled.
    task automatic applyStimulus(input logic wr, input logic two,
                                 input logic [31:0] a1, input logic [31:0] a2,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [1:0] s1, input logic [1:0] s2,
                                 input logic [3:0] st1, input logic [3:0] st2,
                                 input logic [31:0] exp_rd, input logic exp_err);
        int   stall_errs;
        logic got_pulse;
        int   n_wr;
        stall_errs = 0;
        got_pulse  = 0;
        n_wr = wr ? (two ? 2 : 1) : 0;
        if (wr) begin
            exp_aw.push_back('{a1, s1});
            exp_w.push_back('{d1, st1});
            if (two) begin
                exp_aw.push_back('{a2, s2});
                exp_w.push_back('{d2, st2});
            end
        end else begin
            exp_ar.push_back('{a1, s1});
        end
        exp_done.push_back('{!wr, exp_rd, exp_err});
        ar_n = 0; aw_n = 0; w_n = 0; b_n = 0; pulse_n = 0;
        req_wr = wr; req_two = two;
        addr1 = a1; addr2 = a2; data1 = d1; data2 = d2; size1 = s1; size2 = s2;
        req_valid = 1;
        #1;
        if (mem_stall !== 1'b1) stall_errs++;
        for (int i = 0; i < 200 && !got_pulse; i++) begin
            @(negedge clk);
            if (rdata_valid === 1'b1) begin
                got_pulse = 1;
                if (mem_stall !== 1'b0) stall_errs++;
                req_valid = 0;
            end else if (mem_stall !== 1'b1) begin
                stall_errs++;
            end
        end
        req_valid = 0;
        checkOutput("pulse_seen", 32'(got_pulse), 1);
        checkOutput("stall_profile", 32'(stall_errs), 0);
        @(negedge clk);
        checkOutput("ar_count", 32'(ar_n), wr ? 32'd0 : 32'd1);
        checkOutput("aw_count", 32'(aw_n), 32'(n_wr));
        checkOutput("w_count", 32'(w_n), 32'(n_wr));
        checkOutput("b_count", 32'(b_n), 32'(n_wr));
        checkOutput("pulse_count", 32'(pulse_n), 1);
    endtask

    initial begin
        int   bad;
        logic seen;
        req_valid = 0; req_wr = 0; req_two = 0;
        addr1 = 0; addr2 = 0; data1 = 0; data2 = 0; size1 = 0; size2 = 0;
        resetn = 1;
        #2 resetn = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_arvalid", 32'(arvalid), 0);
        checkOutput("rst_awvalid", 32'(awvalid), 0);
        checkOutput("rst_wvalid", 32'(wvalid), 0);
        checkOutput("rst_bready", 32'(bready), 0);
        checkOutput("rst_rready", 32'(rready), 0);
        checkOutput("rst_rdata_valid", 32'(rdata_valid), 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_resp_err", 32'(resp_err), 0);
        resetn = 1;
        @(negedge clk);

        $display("[TB] load word, arready delayed 3 cycles");
        ar_delay = 3; rword_cfg = 32'hDEADBEEF;
        applyStimulus(0, 0, 32'h1000, 32'h0, 32'h0, 32'h0, SIZE_WORD, SIZE_BYTE, 4'h0, 4'h0, 32'hDEADBEEF, 0);
        ar_delay = 0;

        $display("[TB] store byte to lane 3");
        applyStimulus(1, 0, 32'h2003, 32'h0, 32'hAB000000, 32'h0, SIZE_BYTE, SIZE_BYTE, 4'b1000, 4'b0000, 32'h0, 0);

        $display("[TB] split store half then byte");
        applyStimulus(1, 1, 32'h3000, 32'h3002, 32'h0000BEEF, 32'h00CD0000, SIZE_HALF, SIZE_BYTE, 4'b0011, 4'b0100, 32'h0, 0);

        $display("[TB] W before AW, AW before W, same cycle");
        aw_delay = 2; w_delay = 0;
        applyStimulus(1, 0, 32'h4000, 32'h0, 32'h01020304, 32'h0, SIZE_WORD, SIZE_BYTE, 4'b1111, 4'b0000, 32'h0, 0);
        aw_delay = 0; w_delay = 3;
        applyStimulus(1, 0, 32'h4002, 32'h0, 32'h55660000, 32'h0, SIZE_HALF, SIZE_BYTE, 4'b1100, 4'b0000, 32'h0, 0);
        aw_delay = 1; w_delay = 1;
        applyStimulus(1, 0, 32'h4008, 32'h0, 32'h99887766, 32'h0, SIZE_WORD, SIZE_BYTE, 4'b1111, 4'b0000, 32'h0, 0);
        aw_delay = 0; w_delay = 0;

        $display("[TB] misaligned half and word strobes");
        applyStimulus(1, 0, 32'h5003, 32'h0, 32'hEE000000, 32'h0, SIZE_HALF, SIZE_BYTE, 4'b1000, 4'b0000, 32'h0, 0);
        applyStimulus(1, 0, 32'h5001, 32'h0, 32'hCAFEF00D, 32'h0, SIZE_WORD, SIZE_BYTE, 4'b1111, 4'b0000, 32'h0, 0);

        $display("[TB] reset while waiting for write response");
        b_delay = 6;
        exp_aw.push_back('{32'h7000, SIZE_WORD});
        exp_w.push_back('{32'h11223344, 4'b1111});
        req_wr = 1; req_two = 0; addr1 = 32'h7000; data1 = 32'h11223344; size1 = SIZE_WORD;
        req_valid = 1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bready === 1'b1) seen = 1;
        end
        checkOutput("rst_reach_wresp", 32'(seen), 1);
        resetn = 0;
        req_valid = 0;
        #1;
        checkOutput("rst_mid_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 0);
        checkOutput("rst_mid_pulse", 32'(rdata_valid), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rdata_valid !== 1'b0) bad++;
        end
        resetn = 1;
        b_delay = 0;
        repeat (2) begin
            @(negedge clk);
            if (rdata_valid !== 1'b0) bad++;
        end
        checkOutput("rst_no_pulse", 32'(bad), 0);
        r_delay = 2; rword_cfg = 32'h12345678;
        applyStimulus(0, 0, 32'h6004, 32'h0, 32'h0, 32'h0, SIZE_WORD, SIZE_BYTE, 4'h0, 4'h0, 32'h12345678, 0);
        r_delay = 0;

        $display("[TB] error responses");
        bresp_first = 2'b10;
        applyStimulus(1, 1, 32'h8000, 32'h8004, 32'hA5A5A5A5, 32'h5A5A5A5A, SIZE_WORD, SIZE_WORD, 4'b1111, 4'b1111, 32'h0, RESP_EXP);
        bresp_first = AXI_OKAY;
        applyStimulus(1, 0, 32'h8010, 32'h0, 32'h00000077, 32'h0, SIZE_BYTE, SIZE_BYTE, 4'b0001, 4'b0000, 32'h0, 0);
        rresp_cfg = 2'b10; rword_cfg = 32'h0BADF00D;
        applyStimulus(0, 0, 32'h9000, 32'h0, 32'h0, 32'h0, SIZE_WORD, SIZE_BYTE, 4'h0, 4'h0, 32'h0BADF00D, RESP_EXP);
        rresp_cfg = AXI_OKAY; rword_cfg = 32'h00C0FFEE;
        applyStimulus(0, 0, 32'h9004, 32'h0, 32'h0, 32'h0, SIZE_HALF, SIZE_BYTE, 4'h0, 4'h0, 32'h00C0FFEE, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
